// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one off-chip memory port between I-cache and D-cache
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       conflict_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic                own_d_q, own_d_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                d_req, both, win_d;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign i_ready      = i_ready_q;
    assign d_ready      = d_ready_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign conflict_cnt = cnt_q;
    // Arbitrate in IDLE, hold the memory handshake in BUSY, pulse the owner's ready in DONE
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        own_d_d     = own_d_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        cnt_d       = cnt_q;
        d_req       = d_read | d_write;
        both        = i_read & d_req;
        win_d       = d_req & (~i_read | ~last_d_q);
        unique case (state_q)
            IDLE: if (i_read | d_req) begin
                state_d     = BUSY;
                own_d_d     = win_d;
                mem_write_d = win_d & d_write;
                mem_read_d  = ~(win_d & d_write);
                mem_addr_d  = win_d ? d_addr : i_addr;
                mem_wdata_d = win_d ? d_wdata : '0;
                cnt_d       = (both && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
            end
            BUSY: if (mem_ready) begin
                state_d     = DONE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                last_d_d    = own_d_q;
                i_ready_d   = ~own_d_q;
                d_ready_d   = own_d_q;
                i_rdata_d   = (mem_read_q && !own_d_q) ? mem_rdata : i_rdata_q;
                d_rdata_d   = (mem_read_q && own_d_q) ? mem_rdata : d_rdata_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // State and registered outputs; asynchronous active-low reset aborts any transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            own_d_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            own_d_q     <= own_d_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for mem_arbiter
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam logic [DW-1:0] W1 = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C};
    localparam logic [DW-1:0] W2 = {32'hCAFEF00D, 32'h55AA55AA, 32'h12345678, 32'h9ABCDEF0};
    localparam logic [DW-1:0] P1 = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic [15:0]   conflict_cnt;
    logic          auto_mem = 1'b0;
    logic          a_ready = 1'b0;
    logic [DW-1:0] a_rdata = '0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    int            lat = 1;
    int            wcnt = 0;
    logic          prev_strobe = 1'b0;
    int            txn_cnt = 0;
    int            i_rdy_cnt = 0;
    int            d_rdy_cnt = 0;
    int            pass_cnt = 0;
    int            total = 0;
    assign mem_ready = auto_mem ? a_ready : m_ready;
    assign mem_rdata = auto_mem ? a_rdata : m_rdata;
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .conflict_cnt(conflict_cnt)
    );
    always #5 clk = ~clk;
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {4{4'hA, a}};
    endfunction
    // Memory model: answers a strobe after lat+1 negedges with an address-derived line
    always @(negedge clk) begin
        if ((mem_read || mem_write) && !a_ready) begin
            if (wcnt >= lat) begin
                a_ready <= 1'b1;
                a_rdata <= pat(mem_addr);
                wcnt    <= 0;
            end else wcnt <= wcnt + 1;
        end else begin
            a_ready <= 1'b0;
            wcnt    <= 0;
        end
    end
    // Transaction and ready-pulse counters
    always @(negedge clk) begin
        prev_strobe <= mem_read | mem_write;
        if ((mem_read || mem_write) && !prev_strobe) txn_cnt <= txn_cnt + 1;
        if (i_ready) i_rdy_cnt <= i_rdy_cnt + 1;
        if (d_ready) d_rdy_cnt <= d_rdy_cnt + 1;
    end
    task automatic wait_strobe();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_read || mem_write) return;
        end
    endtask
    task automatic wait_ready(output logic gi, output logic gd);
        gi = 1'b0;
        gd = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (i_ready || d_ready) begin
                gi = i_ready;
                gd = d_ready;
                return;
            end
        end
    endtask
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({mem_read, mem_write, mem_addr, mem_wdata, i_rdata, d_rdata, i_ready, d_ready, conflict_cnt} !== '0)
            $display("FAIL reset_outputs: some output nonzero (cnt=%h mem_addr=%h), expected all 0", conflict_cnt, mem_addr);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
    endtask
    task automatic test_i_read();
        auto_mem = 1'b0;
        i_read = 1'b1;
        i_addr = 28'h10;
        @(negedge clk);
        total++;
        if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h10)
            $display("FAIL i_read_strobe: rd/wr=%b addr=%h, expected 10 addr 0000010", {mem_read, mem_write}, mem_addr);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total++;
        if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h10 || i_ready !== 1'b0)
            $display("FAIL i_read_hold: rd/wr=%b addr=%h rdy=%b, expected 10 0000010 0", {mem_read, mem_write}, mem_addr, i_ready);
        else pass_cnt++;
        m_ready = 1'b1;
        m_rdata = P1;
        @(negedge clk);
        m_ready = 1'b0;
        i_read = 1'b0;
        total++;
        if ({i_ready, d_ready} !== 2'b10 || {mem_read, mem_write} !== 2'b00)
            $display("FAIL i_read_ready: i/d_ready=%b rd/wr=%b, expected 10 00", {i_ready, d_ready}, {mem_read, mem_write});
        else pass_cnt++;
        total++;
        if (i_rdata !== P1) $display("FAIL i_read_data: got %h expected %h", i_rdata, P1);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (i_ready !== 1'b0) $display("FAIL i_read_pulse_end: i_ready=%b expected 0", i_ready);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({mem_read, mem_write} !== 2'b00) $display("FAIL i_read_no_regrant: rd/wr=%b expected 00", {mem_read, mem_write});
        else pass_cnt++;
        auto_mem = 1'b1;
    endtask
    task automatic test_tie();
        logic gi, gd;
        i_read = 1'b1;
        i_addr = 28'h20;
        d_write = 1'b1;
        d_addr = 28'h30;
        d_wdata = W1;
        wait_strobe();
        total++;
        if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 28'h30 || mem_wdata !== W1)
            $display("FAIL tie_d_first: rd/wr=%b addr=%h wdata=%h, expected 01 0000030 %h", {mem_read, mem_write}, mem_addr, mem_wdata, W1);
        else pass_cnt++;
        wait_ready(gi, gd);
        d_write = 1'b0;
        total++;
        if ({gi, gd} !== 2'b01) $display("FAIL tie_d_ready: i/d=%b expected 01", {gi, gd});
        else pass_cnt++;
        wait_strobe();
        total++;
        if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h20)
            $display("FAIL tie_i_second: rd/wr=%b addr=%h, expected 10 0000020", {mem_read, mem_write}, mem_addr);
        else pass_cnt++;
        wait_ready(gi, gd);
        i_read = 1'b0;
        total++;
        if ({gi, gd} !== 2'b10 || i_rdata !== pat(28'h20))
            $display("FAIL tie_i_ready: i/d=%b data=%h, expected 10 %h", {gi, gd}, i_rdata, pat(28'h20));
        else pass_cnt++;
        total++;
        if (d_rdata !== '0) $display("FAIL tie_write_keeps_drdata: got %h expected 0", d_rdata);
        else pass_cnt++;
        total++;
        if (conflict_cnt !== 16'd1) $display("FAIL tie_conflict_cnt: got %0d expected 1", conflict_cnt);
        else pass_cnt++;
        @(negedge clk);
    endtask
    task automatic test_alternate();
        logic gi, gd;
        int r0;
        r0 = i_rdy_cnt + d_rdy_cnt;
        i_read = 1'b1;
        i_addr = 28'h50;
        d_read = 1'b1;
        d_addr = 28'h60;
        for (int k = 0; k < 6; k++) begin
            wait_ready(gi, gd);
            if (k == 5) begin
                i_read = 1'b0;
                d_read = 1'b0;
            end
            total++;
            if ({gi, gd} !== ((k % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL alt_owner_%0d: i/d=%b expected %b", k, {gi, gd}, (k % 2 == 0) ? 2'b01 : 2'b10);
            else pass_cnt++;
            total++;
            if ((k % 2 == 0) ? (d_rdata !== pat(28'h60)) : (i_rdata !== pat(28'h50)))
                $display("FAIL alt_data_%0d: i=%h d=%h", k, i_rdata, d_rdata);
            else pass_cnt++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (conflict_cnt !== 16'd7) $display("FAIL alt_conflict_cnt: got %0d expected 7", conflict_cnt);
        else pass_cnt++;
        total++;
        if (i_rdy_cnt + d_rdy_cnt - r0 !== 6) $display("FAIL alt_ready_count: got %0d expected 6", i_rdy_cnt + d_rdy_cnt - r0);
        else pass_cnt++;
    endtask
    task automatic test_dual_op();
        logic gi, gd;
        int r0;
        r0 = d_rdy_cnt;
        d_read = 1'b1;
        d_write = 1'b1;
        d_addr = 28'h44;
        d_wdata = W2;
        wait_strobe();
        total++;
        if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 28'h44 || mem_wdata !== W2)
            $display("FAIL dual_op_write: rd/wr=%b addr=%h wdata=%h, expected 01 0000044 %h", {mem_read, mem_write}, mem_addr, mem_wdata, W2);
        else pass_cnt++;
        wait_ready(gi, gd);
        d_read = 1'b0;
        d_write = 1'b0;
        total++;
        if ({gi, gd} !== 2'b01) $display("FAIL dual_op_ready: i/d=%b expected 01", {gi, gd});
        else pass_cnt++;
        total++;
        if (d_rdata !== pat(28'h60)) $display("FAIL dual_op_drdata: got %h expected %h", d_rdata, pat(28'h60));
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total++;
        if (d_rdy_cnt - r0 !== 1) $display("FAIL dual_op_pulses: got %0d expected 1", d_rdy_cnt - r0);
        else pass_cnt++;
    endtask
    task automatic test_hold();
        logic gi, gd;
        int t0;
        t0 = txn_cnt;
        i_read = 1'b1;
        i_addr = 28'h70;
        wait_ready(gi, gd);
        total++;
        if ({gi, gd} !== 2'b10) $display("FAIL hold_ready: i/d=%b expected 10", {gi, gd});
        else pass_cnt++;
        @(negedge clk);
        i_read = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (txn_cnt - t0 !== 1) $display("FAIL hold_single_txn: got %0d transactions expected 1", txn_cnt - t0);
        else pass_cnt++;
        auto_mem = 1'b0;
        m_rdata = '1;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0000 || txn_cnt - t0 !== 1)
            $display("FAIL stray_ready_idle: rd/wr/ir/dr=%b txns=%0d, expected 0000 1", {mem_read, mem_write, i_ready, d_ready}, txn_cnt - t0);
        else pass_cnt++;
        total++;
        if (i_rdata !== pat(28'h70)) $display("FAIL stray_ready_data: got %h expected %h", i_rdata, pat(28'h70));
        else pass_cnt++;
        auto_mem = 1'b1;
    endtask
    task automatic test_saturate();
        logic gi, gd;
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        total++;
        if (conflict_cnt !== 16'hFFFE) $display("FAIL sat_preload: got %h expected fffe", conflict_cnt);
        else pass_cnt++;
        i_read = 1'b1;
        i_addr = 28'h11;
        d_read = 1'b1;
        d_addr = 28'h22;
        for (int k = 0; k < 3; k++) begin
            wait_ready(gi, gd);
            if (k == 2) begin
                i_read = 1'b0;
                d_read = 1'b0;
            end
            if (k == 0) begin
                total++;
                if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_first: got %h expected ffff", conflict_cnt);
                else pass_cnt++;
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", conflict_cnt);
        else pass_cnt++;
    endtask
    task automatic test_reset_mid();
        logic gi, gd;
        int r0;
        lat = 5;
        d_write = 1'b1;
        d_addr = 28'h30;
        d_wdata = W1;
        wait_strobe();
        total++;
        if (mem_write !== 1'b1) $display("FAIL rst_mid_pre: mem_write=%b expected 1", mem_write);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total++;
        if ({mem_read, mem_write, mem_addr, mem_wdata, i_rdata, d_rdata, i_ready, d_ready, conflict_cnt} !== '0)
            $display("FAIL rst_mid_outputs: cnt=%h mem_addr=%h i_rdata=%h, expected all 0", conflict_cnt, mem_addr, i_rdata);
        else pass_cnt++;
        d_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        lat = 1;
        r0 = i_rdy_cnt + d_rdy_cnt;
        repeat (4) @(negedge clk);
        total++;
        if (i_rdy_cnt + d_rdy_cnt - r0 !== 0 || {mem_read, mem_write} !== 2'b00)
            $display("FAIL rst_mid_aborted: pulses=%0d rd/wr=%b, expected 0 00", i_rdy_cnt + d_rdy_cnt - r0, {mem_read, mem_write});
        else pass_cnt++;
        i_read = 1'b1;
        i_addr = 28'h12;
        d_read = 1'b1;
        d_addr = 28'h34;
        wait_strobe();
        total++;
        if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h34)
            $display("FAIL rst_mid_tie_d: rd/wr=%b addr=%h, expected 10 0000034", {mem_read, mem_write}, mem_addr);
        else pass_cnt++;
        wait_ready(gi, gd);
        i_read = 1'b0;
        d_read = 1'b0;
        total++;
        if ({gi, gd} !== 2'b01 || conflict_cnt !== 16'd1)
            $display("FAIL rst_mid_tie_ready: i/d=%b cnt=%0d, expected 01 1", {gi, gd}, conflict_cnt);
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask
    initial begin
        test_reset();
        test_i_read();
        test_tie();
        test_alternate();
        test_dual_op();
        test_hold();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", pass_cnt, total);
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single off-chip memory port of the pipelined MIPS core between the instruction-cache and data-cache miss/write-back engines. It latches one request at a time, drives the memory handshake until the memory answers, and returns the result with a one-cycle ready pulse to the winning cache. Round-robin selection on simultaneous requests keeps a D-cache write-back burst from starving instruction fetch. A saturating counter reports how often both caches contended.

## Interface
Parameters:
- ADDR_W, 28: block (line) address width.
- DATA_W, 128: line width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_read  in  1  I-cache line-read request.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  DATA_W  line data returned to I-cache.
- i_ready  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line-read request.
- d_write  in  1  D-cache line-write (write-back) request.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  DATA_W  D-cache write data.
- d_rdata  out  DATA_W  line data returned to D-cache.
- d_ready  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completion, one or more cycles high.
- conflict_cnt  out  16  saturating count of contended arbitrations.

## Operation
- States: IDLE, BUSY, DONE. All outputs registered.
- IDLE: if any request is present, latch the winner's op, address and write data, set owner, go to BUSY. No request: stay in IDLE.
- Winner selection: only I requests -> I; only D requests -> D; both -> the requester not served last (last_owner flag). last_owner resets to I, so the first tie after reset goes to D.
- D op encoding: d_write=1 means write, regardless of d_read. d_read=1 with d_write=0 means read. i_read is read only.
- BUSY: drive mem_read or mem_write (exactly one) with the latched mem_addr and mem_wdata. Hold them constant until mem_ready=1. Then capture mem_rdata into the owner's rdata register, update last_owner, go to DONE.
- DONE: assert the owner's *_ready for exactly this cycle, with mem_read=mem_write=0. Ignore all requests. Go to IDLE next edge.
- i_rdata/d_rdata keep the last captured value until overwritten. The non-owner's rdata is never modified. A write leaves d_rdata unchanged.
- conflict_cnt: increments by 1 on each IDLE->BUSY transition in which both I and D requested. Saturates at 16'hFFFF.
- mem_ready outside BUSY is ignored.
- Request deasserted during BUSY is ignored; the latched transaction completes and the ready pulse is still issued.
- Requester inputs change mid-BUSY: latched values are used; the new inputs have no effect.

## Timing
- Reset (async assert): state=IDLE, last_owner=I, all outputs 0 (strobes, ready pulses, mem_addr, mem_wdata, rdata registers, conflict_cnt). Reset mid-transaction aborts it immediately; no ready pulse is issued.
- A request sampled at edge E puts mem_read or mem_write high in the cycle after E.
- mem_ready sampled high at edge F makes *_ready high for the cycle after F, with rdata valid in that same cycle. The arbiter is back in IDLE one cycle later.
- Minimum gap: 2 cycles from a ready pulse to the next memory strobe. The DONE cycle and the IDLE sampling cycle together absorb the requester's one-cycle request deassert latency, so a completed request is never re-granted.
- Best-case turnaround with mem_ready returned one cycle after the strobe: request to *_ready is 3 edges.

## Test plan
- Reset check: assert rst low mid-BUSY -> all outputs 0 immediately. After release, an I read of 0x10 with mem_ready after 4 cycles -> mem_read high with mem_addr=0x10, then i_ready pulses once with i_rdata equal to the driven 128-bit pattern.
- Simultaneous I read 0x20 and D write 0x30 from reset -> D served first (mem_write, mem_wdata=d_wdata), then I; conflict_cnt=1.
- Sustained dual requests for 6 transactions -> grants alternate D,I,D,I,D,I; conflict_cnt=6; no ready pulse is ever delivered to the non-owner.
- d_read and d_write both high on 0x44 -> mem_write only; d_rdata unchanged; d_ready pulses once.
- Requester holds its request through DONE and drops it one cycle after ready -> exactly one memory transaction occurs. Stray mem_ready pulses in IDLE -> no state change.
- Preload conflict_cnt to 16'hFFFE, then run 3 contended arbitrations -> conflict_cnt reads 16'hFFFF and holds there.
